// File: rtl/ctrl_axi_lite_initiator_if.sv
// AXI-Lite bus bundle between the control-register initiator and its slave.
// Parameters: AddrWidth (address bits), DataWidth (data bits; strobe is DataWidth/8).
// Channels: AW (addr/prot/valid/ready), W (data/strb/valid/ready), B (resp/valid/ready),
//           AR (addr/prot/valid/ready), R (data/resp/valid/ready).
// Modports: master (initiator side), slave (target side).
interface ctrl_axi_lite_initiator_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  logic [AddrWidth-1:0]   aw_addr;
  logic [2:0]             aw_prot;
  logic                   aw_valid;
  logic                   aw_ready;
  logic [DataWidth-1:0]   w_data;
  logic [DataWidth/8-1:0] w_strb;
  logic                   w_valid;
  logic                   w_ready;
  logic [1:0]             b_resp;
  logic                   b_valid;
  logic                   b_ready;
  logic [AddrWidth-1:0]   ar_addr;
  logic [2:0]             ar_prot;
  logic                   ar_valid;
  logic                   ar_ready;
  logic [DataWidth-1:0]   r_data;
  logic [1:0]             r_resp;
  logic                   r_valid;
  logic                   r_ready;

  modport master (
    output aw_addr, aw_prot, aw_valid, input aw_ready,
    output w_data, w_strb, w_valid, input w_ready,
    input b_resp, b_valid, output b_ready,
    output ar_addr, ar_prot, ar_valid, input ar_ready,
    input r_data, r_resp, r_valid, output r_ready
  );

  modport slave (
    input aw_addr, aw_prot, aw_valid, output aw_ready,
    input w_data, w_strb, w_valid, output w_ready,
    output b_resp, b_valid, input b_ready,
    input ar_addr, ar_prot, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid, input r_ready
  );
endinterface

// File: rtl/ctrl_axi_lite_initiator.sv
// AXI-Lite initiator: converts one valid/ready register-access request into a
// single AXI-Lite read or write and returns the result on a valid/ready
// response channel. One transaction outstanding at a time.
// Optional feature macro: CTRL_INIT_ERR_CNT_EN adds ErrCntWidth and err_cnt_o,
// a saturating count of non-OKAY responses cleared only by reset.
// Ports:
//   clk_i, rst_i (async, active-high)
//   req_valid_i/req_ready_o, req_write_i, req_addr_i, req_wdata_i, req_strb_i
//   rsp_valid_o/rsp_ready_i, rsp_rdata_o (0 for writes), rsp_err_o (AXI resp)
//   busy_o (high outside IDLE)
//   axi_lite_master (AXI-Lite bus, master modport)
//   err_cnt_o (only with CTRL_INIT_ERR_CNT_EN)
module ctrl_axi_lite_initiator #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
`ifdef CTRL_INIT_ERR_CNT_EN
  ,
  parameter int unsigned ErrCntWidth = 8
`endif
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_write_i,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic [DataWidth-1:0]   req_wdata_i,
  input  logic [DataWidth/8-1:0] req_strb_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DataWidth-1:0]   rsp_rdata_o,
  output logic [1:0]             rsp_err_o,
  output logic                   busy_o,
  ctrl_axi_lite_initiator_if.master axi_lite_master
`ifdef CTRL_INIT_ERR_CNT_EN
  ,
  output logic [ErrCntWidth-1:0] err_cnt_o
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_B,
    RD_AR,
    RD_R,
    RSP
  } state_e;

  state_e state_q, state_d;

  logic [AddrWidth-1:0]   addr_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [DataWidth/8-1:0] strb_q;
  logic                   aw_done_q;
  logic                   w_done_q;
  logic [DataWidth-1:0]   rdata_q;
  logic [1:0]             err_q;

  logic aw_valid, w_valid, b_ready, ar_valid, r_ready;
  logic aw_ready, w_ready, b_valid, ar_ready, r_valid;
  logic req_hs, aw_hs, w_hs, b_hs, r_hs;

  assign aw_ready = axi_lite_master.aw_ready;
  assign w_ready  = axi_lite_master.w_ready;
  assign b_valid  = axi_lite_master.b_valid;
  assign ar_ready = axi_lite_master.ar_ready;
  assign r_valid  = axi_lite_master.r_valid;

  assign req_hs = req_valid_i & req_ready_o;
  assign aw_hs  = aw_valid & aw_ready;
  assign w_hs   = w_valid & w_ready;
  assign b_hs   = b_valid & b_ready;
  assign r_hs   = r_valid & r_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // All handshake outputs decode the state register directly, so an
  // asynchronous reset drops every valid/ready in the same cycle.
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    aw_valid    = 1'b0;
    w_valid     = 1'b0;
    b_ready     = 1'b0;
    ar_valid    = 1'b0;
    r_ready     = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          state_d = req_write_i ? WR : RD_AR;
        end
      end
      WR: begin
        aw_valid = ~aw_done_q;
        w_valid  = ~w_done_q;
        // Leave as soon as both channels have handshaken, counting a
        // handshake in this very cycle, so a zero-wait slave sees B one
        // cycle after AW/W.
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d = WR_B;
        end
      end
      WR_B: begin
        b_ready = 1'b1;
        if (b_valid) begin
          state_d = RSP;
        end
      end
      RD_AR: begin
        ar_valid = 1'b1;
        if (ar_ready) begin
          state_d = RD_R;
        end
      end
      RD_R: begin
        r_ready = 1'b1;
        if (r_valid) begin
          state_d = RSP;
        end
      end
      RSP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= '0;
    end else begin
      if (req_hs) begin
        addr_q    <= req_addr_i;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        if (req_write_i) begin
          wdata_q <= req_wdata_i;
          strb_q  <= req_strb_i;
        end
      end
      if (aw_hs) begin
        aw_done_q <= 1'b1;
      end
      if (w_hs) begin
        w_done_q <= 1'b1;
      end
      if (b_hs) begin
        err_q   <= axi_lite_master.b_resp;
        rdata_q <= '0;
      end
      if (r_hs) begin
        err_q   <= axi_lite_master.r_resp;
        rdata_q <= axi_lite_master.r_data;
      end
    end
  end

`ifdef CTRL_INIT_ERR_CNT_EN
  logic [ErrCntWidth-1:0] err_cnt_q;
  logic                   resp_done;
  logic [1:0]             resp_code;

  assign resp_done = b_hs | r_hs;
  assign resp_code = b_hs ? axi_lite_master.b_resp : axi_lite_master.r_resp;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else if (resp_done && (resp_code != 2'b00) && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ErrCntWidth'(1);
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

  assign busy_o      = (state_q != IDLE);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  assign axi_lite_master.aw_valid = aw_valid;
  assign axi_lite_master.aw_addr  = addr_q;
  assign axi_lite_master.aw_prot  = 3'b000;
  assign axi_lite_master.w_valid  = w_valid;
  assign axi_lite_master.w_data   = wdata_q;
  assign axi_lite_master.w_strb   = strb_q;
  assign axi_lite_master.b_ready  = b_ready;
  assign axi_lite_master.ar_valid = ar_valid;
  assign axi_lite_master.ar_addr  = addr_q;
  assign axi_lite_master.ar_prot  = 3'b000;
  assign axi_lite_master.r_ready  = r_ready;

endmodule

// File: tb/tb_ctrl_axi_lite_initiator.sv
// Bench for ctrl_axi_lite_initiator: memory-backed AXI-Lite slave with
// programmable per-channel wait states, a table of directed transactions,
// cycle-exact corner-case sequences and a randomized run checked against a
// transaction-level reference model (word array + address-decoded responses).
module tb_ctrl_axi_lite_initiator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        busy;
`ifdef CTRL_INIT_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  ctrl_axi_lite_initiator_if #(.AddrWidth(32), .DataWidth(32)) axi ();

  ctrl_axi_lite_initiator #(
    .AddrWidth(32),
    .DataWidth(32)
`ifdef CTRL_INIT_ERR_CNT_EN
    ,
    .ErrCntWidth(8)
`endif
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_write_i    (req_write),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .req_strb_i     (req_strb),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err),
    .busy_o         (busy),
    .axi_lite_master(axi)
`ifdef CTRL_INIT_ERR_CNT_EN
    ,
    .err_cnt_o      (err_cnt)
`endif
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Address map shared by the slave and the model: bit 13 -> DECERR,
  // bit 12 -> SLVERR, otherwise OKAY on a 16-word memory indexed by addr[5:2].
  function automatic logic [1:0] map_resp(input logic [31:0] a);
    if (a[13]) return 2'b11;
    if (a[12]) return 2'b10;
    return 2'b00;
  endfunction

  // ---------------- slave ----------------
  int unsigned cfg_aw_lat, cfg_w_lat, cfg_b_lat, cfg_ar_lat, cfg_r_lat;
  logic [31:0] slv_mem [16] = '{default: '0};
  bit          aw_got, w_got, ar_got;
  int unsigned aw_wait, w_wait, b_wait, ar_wait, r_wait;
  int unsigned cnt_aw = 0, cnt_w = 0, cnt_b = 0, cnt_ar = 0, cnt_r = 0;
  logic [31:0] last_aw_addr, last_w_data, last_ar_addr;
  logic [3:0]  last_w_strb;
  bit          prot_bad = 1'b0;

  // Decisions are taken on the falling edge; handshakes for the next rising
  // edge are exactly valid && ready as they stand now.
  always @(negedge clk) begin
    if (rst) begin
      axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.b_valid = 1'b0;
      axi.ar_ready = 1'b0; axi.r_valid = 1'b0;
      axi.b_resp = 2'b00; axi.r_resp = 2'b00; axi.r_data = '0;
      aw_got = 0; w_got = 0; ar_got = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    end else begin
      if (aw_got && w_got) begin
        if (!axi.b_valid) begin
          if (b_wait >= cfg_b_lat) begin
            axi.b_valid = 1'b1;
            axi.b_resp  = map_resp(last_aw_addr);
          end else b_wait++;
        end
      end else begin
        axi.b_valid = 1'b0;
        axi.b_resp  = 2'($urandom);
      end
      if (axi.b_valid && axi.b_ready) begin
        cnt_b++;
        if (axi.b_resp == 2'b00)
          for (int unsigned i = 0; i < 4; i++)
            if (last_w_strb[i]) slv_mem[last_aw_addr[5:2]][8*i +: 8] = last_w_data[8*i +: 8];
        aw_got = 0; w_got = 0; b_wait = 0;
      end
      axi.aw_ready = 1'b0;
      if (axi.aw_valid && !aw_got) begin
        if (aw_wait >= cfg_aw_lat) begin
          axi.aw_ready = 1'b1; aw_got = 1; aw_wait = 0; cnt_aw++;
          last_aw_addr = axi.aw_addr;
          if (axi.aw_prot != 3'b000) prot_bad = 1'b1;
        end else aw_wait++;
      end
      axi.w_ready = 1'b0;
      if (axi.w_valid && !w_got) begin
        if (w_wait >= cfg_w_lat) begin
          axi.w_ready = 1'b1; w_got = 1; w_wait = 0; cnt_w++;
          last_w_data = axi.w_data; last_w_strb = axi.w_strb;
        end else w_wait++;
      end
      if (ar_got) begin
        if (!axi.r_valid) begin
          if (r_wait >= cfg_r_lat) begin
            axi.r_valid = 1'b1;
            axi.r_resp  = map_resp(last_ar_addr);
            axi.r_data  = (axi.r_resp == 2'b00) ? slv_mem[last_ar_addr[5:2]] : 32'hDEAD_BEEF;
          end else r_wait++;
        end
      end else begin
        axi.r_valid = 1'b0;
        axi.r_resp  = 2'($urandom);
        axi.r_data  = $urandom;
      end
      if (axi.r_valid && axi.r_ready) begin
        cnt_r++; ar_got = 0; r_wait = 0;
      end
      axi.ar_ready = 1'b0;
      if (axi.ar_valid && !ar_got) begin
        if (ar_wait >= cfg_ar_lat) begin
          axi.ar_ready = 1'b1; ar_got = 1; ar_wait = 0; cnt_ar++;
          last_ar_addr = axi.ar_addr;
          if (axi.ar_prot != 3'b000) prot_bad = 1'b1;
        end else ar_wait++;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [16] = '{default: '0};
  int unsigned ref_errs = 0;
  int unsigned exp_aw = 0, exp_w = 0, exp_b = 0, exp_ar = 0, exp_r = 0;

  task automatic model_txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] er, output logic [1:0] ee);
    ee = map_resp(a);
    if (wr) begin
      er = '0;
      if (ee == 2'b00)
        for (int unsigned i = 0; i < 4; i++)
          if (s[i]) ref_mem[a[5:2]][8*i +: 8] = d[8*i +: 8];
      exp_aw++; exp_w++; exp_b++;
    end else begin
      er = (ee == 2'b00) ? ref_mem[a[5:2]] : 32'hDEAD_BEEF;
      exp_ar++; exp_r++;
    end
    if (ee != 2'b00) ref_errs++;
  endtask

  function automatic logic [31:0] sat_errs();
    return (ref_errs > 255) ? 32'd255 : ref_errs;
  endfunction

  task automatic set_lat(input int unsigned aw, input int unsigned w, input int unsigned b,
                         input int unsigned ar, input int unsigned r);
    cfg_aw_lat = aw; cfg_w_lat = w; cfg_b_lat = b; cfg_ar_lat = ar; cfg_r_lat = r;
  endtask

  // Entered just after a rising edge; returns just after the accepting edge.
  task automatic send_req(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int unsigned n = 0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_strb = s;
    @(negedge clk);
    while (!req_ready && n < 100) begin n++; @(negedge clk); end
    if (n >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL req_accept_timeout: req_ready never seen within 100 cycles");
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_strb = 4'($urandom);
  endtask

  task automatic get_rsp(input string name, input logic [31:0] exp_rd, input logic [1:0] exp_er,
                         input int unsigned hold);
    int unsigned n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_rsp_timeout: rsp_valid never seen within 200 cycles", name);
      return;
    end
    check({name, "_rdata"}, rsp_rdata, exp_rd);
    check({name, "_err"}, 32'(rsp_err), 32'(exp_er));
    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check({name, "_hold_rdata"}, rsp_rdata, exp_rd);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic run_txn(input string name, input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int unsigned hold, input bit use_exp,
                         input logic [31:0] exp_rd, input logic [1:0] exp_er);
    logic [31:0] mr;
    logic [1:0]  me;
    model_txn(wr, a, d, s, mr, me);
    if (!use_exp) begin exp_rd = mr; exp_er = me; end
    send_req(wr, a, d, s);
    get_rsp(name, exp_rd, exp_er, hold);
    if (wr) begin
      check({name, "_aw_addr"}, last_aw_addr, a);
      check({name, "_w_data"}, last_w_data, d);
      check({name, "_w_strb"}, 32'(last_w_strb), 32'(s));
    end else begin
      check({name, "_ar_addr"}, last_ar_addr, a);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int unsigned aw_lat, w_lat, b_lat, ar_lat, r_lat, hold;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] er, d0, d1;
    logic [1:0]  ee;
    int unsigned b0;

    vecs[0]  = '{1'b1, 32'h0000_0004, 32'h0000_0003, 4'hF, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 2'b00};
    vecs[1]  = '{1'b1, 32'h0000_0014, 32'h0000_0100, 4'hF, 1, 2, 1, 0, 0, 0, 32'h0000_0000, 2'b00};
    vecs[2]  = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 0, 0, 0, 2, 1, 2, 32'h0000_0100, 2'b00};
    vecs[3]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 0, 0, 0, 0, 0, 0, 32'h0000_0003, 2'b00};
    vecs[4]  = '{1'b1, 32'h0000_0004, 32'hAABB_CCDD, 4'h5, 2, 0, 0, 0, 0, 1, 32'h0000_0000, 2'b00};
    vecs[5]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 0, 0, 0, 1, 3, 0, 32'h00BB_00DD, 2'b00};
    vecs[6]  = '{1'b1, 32'h0000_0008, 32'h1234_5678, 4'h0, 0, 1, 0, 0, 0, 0, 32'h0000_0000, 2'b00};
    vecs[7]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 2'b00};
    vecs[8]  = '{1'b0, 32'h0000_1014, 32'h0,         4'h0, 0, 0, 0, 0, 2, 0, 32'hDEAD_BEEF, 2'b10};
    vecs[9]  = '{1'b1, 32'h0000_2004, 32'h1111_1111, 4'hF, 0, 0, 2, 0, 0, 0, 32'h0000_0000, 2'b11};
    vecs[10] = '{1'b0, 32'h0000_0006, 32'h0,         4'h0, 0, 0, 0, 0, 0, 0, 32'h00BB_00DD, 2'b00};
    vecs[11] = '{1'b0, 32'h0000_2004, 32'h0,         4'h0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 2'b11};

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
    rsp_ready = 1'b0;
    set_lat(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);

    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valids", {28'd0, axi.aw_valid, axi.w_valid, axi.ar_valid, 1'b0}, 32'd0);
    check("rst_readies", {30'd0, axi.b_ready, axi.r_ready}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
`ifdef CTRL_INIT_ERR_CNT_EN
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Zero-wait write: handshake cycle 0, AW/W cycle 1, B cycle 2, response cycle 3.
    model_txn(1'b1, 32'h4, 32'h3, 4'hF, er, ee);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h4; req_wdata = 32'h3; req_strb = 4'hF;
    @(negedge clk);
    check("lat_c0_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check("lat_c1_aw_w_valid", {30'd0, axi.aw_valid, axi.w_valid}, 32'd3);
    check("lat_c1_aw_addr", axi.aw_addr, 32'h4);
    check("lat_c1_w_data", axi.w_data, 32'h3);
    check("lat_c1_w_strb", 32'(axi.w_strb), 32'hF);
    check("lat_c1_busy_ready", {30'd0, busy, req_ready}, 32'd2);
    check("lat_c1_ar_valid", 32'(axi.ar_valid), 32'd0);
    @(negedge clk);
    check("lat_c2_b_ready", 32'(axi.b_ready), 32'd1);
    check("lat_c2_aw_w_valid", {30'd0, axi.aw_valid, axi.w_valid}, 32'd0);
    check("lat_c2_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("lat_c3_rsp_valid", 32'(rsp_valid), 32'd1);
    check("lat_c3_err", 32'(rsp_err), 32'(ee));
    check("lat_c3_rdata", rsp_rdata, er);
    check("lat_c3_b_ready", 32'(axi.b_ready), 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("lat_c4_idle", {29'd0, busy, req_ready, rsp_valid}, 32'd2);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      set_lat(vecs[i].aw_lat, vecs[i].w_lat, vecs[i].b_lat, vecs[i].ar_lat, vecs[i].r_lat);
      run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
              vecs[i].hold, 1'b1, vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Skewed write: W accepted in cycle 1, AW in cycle 4, B from cycle 5.
    set_lat(3, 0, 0, 0, 0);
    b0 = cnt_b;
    model_txn(1'b1, 32'h18, 32'hCAFE_0001, 4'hF, er, ee);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h18; req_wdata = 32'hCAFE_0001; req_strb = 4'hF;
    @(negedge clk);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check("skew_c1_valids", {30'd0, axi.aw_valid, axi.w_valid}, 32'd3);
    @(negedge clk);
    check("skew_c2_valids", {30'd0, axi.aw_valid, axi.w_valid}, 32'd2);
    check("skew_c2_b_ready", 32'(axi.b_ready), 32'd0);
    @(negedge clk);
    check("skew_c3_valids", {30'd0, axi.aw_valid, axi.w_valid}, 32'd2);
    @(negedge clk);
    check("skew_c4_valids", {30'd0, axi.aw_valid, axi.w_valid}, 32'd2);
    check("skew_c4_b_ready", 32'(axi.b_ready), 32'd0);
    @(negedge clk);
    check("skew_c5_valids", {30'd0, axi.aw_valid, axi.w_valid}, 32'd0);
    check("skew_c5_b_ready", 32'(axi.b_ready), 32'd1);
    @(posedge clk); #1;
    get_rsp("skew", er, ee, 0);
    repeat (3) @(negedge clk);
    check("skew_one_b", cnt_b, b0 + 1);
    @(posedge clk); #1;

    // Response backpressure: rsp_ready low for 5 cycles with a request waiting.
    set_lat(0, 0, 0, 0, 0);
    model_txn(1'b0, 32'h14, 32'h0, 4'h0, er, ee);
    send_req(1'b0, 32'h14, 32'h0, 4'h0);
    begin
      int unsigned n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 50) begin n++; @(negedge clk); end
      if (n >= 50) begin
        n_cmp++; n_bad++;
        $display("FAIL bp_rsp_timeout: rsp_valid never seen within 50 cycles");
      end
    end
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1C; req_wdata = 32'h5A5A_5A5A; req_strb = 4'hF;
    for (int unsigned i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_rdata", rsp_rdata, er);
      check("bp_hold_err", 32'(rsp_err), 32'(ee));
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    check("bp_req_ready_last", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_after_release", {30'd0, req_ready, rsp_valid}, 32'd2);
    model_txn(1'b1, 32'h1C, 32'h5A5A_5A5A, 4'hF, er, ee);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check("bp_next_accepted", {30'd0, axi.aw_valid, busy}, 32'd3);
    @(posedge clk); #1;
    get_rsp("bp_next", er, ee, 0);

    // Randomized traffic against the reference model.
    for (int unsigned t = 0; t < 40; t++) begin
      logic [31:0] a;
      int unsigned eb;
      eb = $urandom_range(0, 7);
      a = ($urandom & 32'h3F) | ((eb == 6) ? 32'h1000 : (eb == 7) ? 32'h2000 : 32'h0);
      set_lat($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
      run_txn($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 2), 1'b0, 32'h0, 2'b00);
    end
`ifdef CTRL_INIT_ERR_CNT_EN
    check("rnd_err_cnt", 32'(err_cnt), sat_errs());
`endif

    // Reset while AW/W are pending.
    set_lat(10, 10, 0, 0, 0);
    send_req(1'b1, 32'h20, 32'h7777_7777, 4'hF);
    @(negedge clk);
    check("rstmid_aw_valid_before", 32'(axi.aw_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rstmid_valids_dropped", {30'd0, axi.aw_valid, axi.w_valid}, 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    ref_errs = 0;
    set_lat(0, 0, 0, 0, 0);
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstmid_after", {29'd0, req_ready, rsp_valid, axi.aw_valid}, 32'd4);
    end
`ifdef CTRL_INIT_ERR_CNT_EN
    check("rstmid_err_cnt", 32'(err_cnt), 32'd0);
`endif
    @(posedge clk); #1;
    run_txn("rstmid_read", 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, 32'h0, 2'b00);

`ifdef CTRL_INIT_ERR_CNT_EN
    for (int unsigned i = 0; i < 3; i++)
      run_txn("cnt_slverr", 1'b0, 32'h1014, 32'h0, 4'h0, 0, 1'b1, 32'hDEAD_BEEF, 2'b10);
    check("cnt_three", 32'(err_cnt), 32'd3);
    for (int unsigned i = 0; i < 300; i++)
      run_txn("cnt_sat", 1'b0, 32'h1008, 32'h0, 4'h0, 0, 1'b0, 32'h0, 2'b00);
    check("cnt_saturated", 32'(err_cnt), 32'd255);
    check("cnt_model", 32'(err_cnt), sat_errs());
`endif

    repeat (3) @(negedge clk);
    check("total_aw", cnt_aw, exp_aw);
    check("total_w", cnt_w, exp_w);
    check("total_b", cnt_b, exp_b);
    check("total_ar", cnt_ar, exp_ar);
    check("total_r", cnt_r, exp_r);
    check("prot_zero", 32'(prot_bad), 32'd0);

    d0 = n_cmp; d1 = n_bad;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", d0, d1);
    $finish;
  end

endmodule
